// File: rtl/shl_seq.sv
// shl_seq: sequential logical left shifter (SLL unit for the multi-cycle datapath).
//
// The shift is decomposed into log2(WIDTH) power-of-two stages (16,8,4,2,1 for the
// defaults). One stage is applied per clock, starting from the most significant
// shift-amount bit.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   request valid
//   in_ready   unit idle and able to accept a request
//   din        operand, sampled on accept
//   shamt      unsigned shift amount, sampled on accept
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts result
//   dout       din << shamt, zero-filled, truncated to WIDTH
//
// Build option: define SHL_ZERO_BYPASS_EN so that a shamt==0 request skips BUSY and
// lands in DONE on its accept edge. The port list is the same in both builds.

module shl_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout
);

  // Stage index width: just wide enough to select one bit of the shift amount.
  localparam int unsigned KW = (SHW > 1) ? $clog2(SHW) : 1;
  localparam logic [KW-1:0] KFirst = KW'(SHW - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   sh_q, sh_d;
  logic [KW-1:0]    k_q, k_d;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    k_d     = k_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          acc_d   = din;
          sh_d    = shamt;
          k_d     = KFirst;
          state_d = StBusy;
`ifdef SHL_ZERO_BYPASS_EN
          // Nothing to shift: present the operand straight away.
          if (shamt == '0) begin
            state_d = StDone;
          end
`endif
        end
      end
      StBusy: begin
        // Stage k shifts by 2**k when bit k of the amount is set.
        if (sh_q[k_q]) begin
          acc_d = acc_q << (WIDTH'(1) << k_q);
        end
        if (k_q == '0) begin
          state_d = StDone;
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        // Unused encoding: recover to idle.
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      sh_q    <= '0;
      k_q     <= KFirst;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      k_q     <= k_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign dout      = acc_q;

endmodule

// File: tb/tb_shl_seq.sv
// Self-checking bench for shl_seq: directed steps, expected results queued at issue
// and compared when the unit presents them.

module tb_shl_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] din;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] sb[$];

  shl_seq #(
    .WIDTH(32),
    .SHW  (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (din),
    .shamt    (shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request at a negedge; returns just after its accept edge.
  task automatic issue(input logic [31:0] d, input logic [4:0] s, input string tag);
    logic [31:0] e;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    din      = d;
    shamt    = s;
    e        = d << s;
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid shows, then compare dout.
  task automatic wait_out(input int exp_lat, input string tag);
    int cyc;
    logic [31:0] e;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxx_xxxx;
    check({tag, "_dout"}, 64'(dout), 64'(e));
  endtask

  task automatic ack(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_ack_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_ack_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int zero_lat;
    logic [31:0] held;
    logic seen;
`ifdef SHL_ZERO_BYPASS_EN
    zero_lat = 0;  // accept edge itself lands in DONE
`else
    zero_lat = 5;
`endif
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    shamt     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);

    // 1: same operand, increasing amounts.
    issue(32'h0000_0400, 5'd1, "t1a");  wait_out(5, "t1a");  ack("t1a");
    issue(32'h0000_0400, 5'd5, "t1b");  wait_out(5, "t1b");  ack("t1b");
    issue(32'h0000_0400, 5'd11, "t1c"); wait_out(5, "t1c");  ack("t1c");

    // 2: truncation and the largest amount.
    issue(32'hFFFF_FC00, 5'd11, "t2a"); wait_out(5, "t2a");  ack("t2a");
    issue(32'h0000_0001, 5'd31, "t2b"); wait_out(5, "t2b");  ack("t2b");
    issue(32'hA5A5_5A5A, 5'd31, "t2c"); wait_out(5, "t2c");  ack("t2c");

    // 3: zero amount.
    issue(32'hDEAD_BEEF, 5'd0, "t3");   wait_out(zero_lat, "t3");

    // 4: backpressure in DONE with a competing request on the input.
    held     = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    din      = 32'h1234_5678;
    shamt    = 5'd4;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      check("t4_dout_stable", 64'(dout), 64'(held));
      check("t4_in_ready_low", 64'(in_ready), 64'd0);
      check("t4_out_valid_held", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("t4_release_in_ready", 64'(in_ready), 64'd1);
    check("t4_release_out_valid", 64'(out_valid), 64'd0);
    sb.push_back(32'h2345_6780);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(5, "t4_new");
    ack("t4_new");

    // 5: reset while BUSY with k==2 discards the request.
    issue(32'h0000_0001, 5'd3, "t5_abort");
    void'(sb.pop_back());
    @(posedge clk);  // k=3
    @(posedge clk);  // k=2
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_dout", 64'(dout), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("t5_no_stale_result", 64'(seen), 64'd0);
    issue(32'h0000_0003, 5'd4, "t5_next"); wait_out(5, "t5_next"); ack("t5_next");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
